// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one Avalon-style master port between an instruction-fetch
//   requester (read only) and a data requester (read/write). One transaction
//   is in flight at a time. The state sequence is IDLE -> BUS_I/BUS_D -> DONE
//   -> IDLE. Every output is registered.
//
//   Configuration macro:
//     ARB_ROUND_ROBIN_EN  defined   : contended grants alternate. The requester
//                                     not served most recently wins, and the
//                                     first contended grant goes to fetch.
//                         undefined : data always wins a contended grant.
//
//   Parameters:
//     WAIT_MAX      number of waitrequest cycles before a transaction is
//                   abandoned (1..65535)
//
//   Ports:
//     clk, reset    clock, synchronous active-high reset
//     i_req/i_addr  fetch request (level) and word address
//     i_rdata/i_ack fetch read data and one-cycle completion pulse
//     d_req/d_we/d_addr/d_wdata/d_be
//                   data request (level), write flag, address, write data,
//                   byte enables
//     d_rdata/d_ack data read data and one-cycle completion pulse
//     m_*           master port: address, read, write, byteenable,
//                   writedata, waitrequest, readdata
//     err           sticky bus-timeout flag, cleared only by reset
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} state_t;

    // A stalled cycle that arrives with the counter at this value is the
    // WAIT_MAX-th stall, so that cycle abandons the transaction.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // This bit is 1 when data was the last requester granted. It resets to
    // data, so the first contended grant goes to fetch.
    logic last_d;

    always_comb begin
        grant_d = d_req && (!i_req || !last_d);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 16'd0;
            m_address    <= 32'd0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_byteenable <= 4'd0;
            m_writedata  <= 32'd0;
            i_rdata      <= 32'd0;
            d_rdata      <= 32'd0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            err          <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d       <= 1'b1;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // The request fields are captured here once. They stay
                    // in the m_* registers for the whole bus phase.
                    if (grant_d) begin
                        state        <= BUS_D;
                        m_address    <= d_addr;
                        m_read       <= !d_we;
                        m_write      <= d_we;
                        m_byteenable <= d_be;
                        m_writedata  <= d_wdata;
                        wait_cnt     <= 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d       <= 1'b1;
`endif
                    end else if (i_req) begin
                        state        <= BUS_I;
                        m_address    <= i_addr;
                        m_read       <= 1'b1;
                        m_write      <= 1'b0;
                        m_byteenable <= 4'hF;
                        wait_cnt     <= 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d       <= 1'b0;
`endif
                    end
                end
                BUS_I, BUS_D: begin
                    if (!m_waitrequest) begin
                        state   <= DONE;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        if (state == BUS_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_readdata;
                        end else begin
                            d_ack <= 1'b1;
                            // A write leaves the data read register untouched.
                            if (m_read) d_rdata <= m_readdata;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Timeout: drop the bus, flag the error and still ack
                        // the owner so that it does not hang. The owner's read
                        // data is zeroed.
                        state    <= DONE;
                        m_read   <= 1'b0;
                        m_write  <= 1'b0;
                        err      <= 1'b1;
                        wait_cnt <= wait_cnt + 16'd1;
                        if (state == BUS_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= 32'd0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= 32'd0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                // Requests are not looked at in DONE. A request that is still
                // held gets arbitrated again in the IDLE cycle that follows.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, i_ack, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, m_byteenable;
    logic [31:0] m_address, m_writedata, m_readdata;
    logic        m_read, m_write, m_waitrequest, err;

    int checks   = 0;
    int failures = 0;
    int both_seen = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .err(err)
    );

    // The strobes must never be high together.
    always @(negedge clk) if (m_read && m_write) both_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        dside;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int n, input vec_t v);
        int cyc;
        i_req = !v.dside;
        d_req = v.dside;
        i_addr = v.addr;
        d_addr = v.addr;
        d_we = v.we;
        d_wdata = v.wdata;
        d_be = v.be;
        m_readdata = v.rdata;
        step();  // grant edge, now in the bus phase
        chk($sformatf("v%0d_rd", n), {31'd0, m_read}, {31'd0, v.exp_rd});
        chk($sformatf("v%0d_wr", n), {31'd0, m_write}, {31'd0, v.exp_wr});
        chk($sformatf("v%0d_addr", n), m_address, v.addr);
        chk($sformatf("v%0d_be", n), {28'd0, m_byteenable}, {28'd0, v.exp_be});
        if (v.exp_wr) chk($sformatf("v%0d_wdata", n), m_writedata, v.wdata);
        cyc = 0;
        while (!(i_ack || d_ack) && cyc < 20) begin
            m_waitrequest = (cyc < v.waits);
            step();
            cyc++;
            if (!(i_ack || d_ack)) begin
                chk($sformatf("v%0d_hold", n), {m_address[29:0], m_read, m_write},
                    {v.addr[29:0], v.exp_rd, v.exp_wr});
            end
        end
        chk($sformatf("v%0d_lat", n), cyc, v.exp_lat);
        chk($sformatf("v%0d_acks", n), {30'd0, i_ack, d_ack}, {30'd0, !v.dside, v.dside});
        chk($sformatf("v%0d_rdata", n), v.dside ? d_rdata : i_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", n), {31'd0, err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_strobes", n), {30'd0, m_read, m_write}, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        m_waitrequest = 1'b0;
        step();  // DONE -> IDLE
        chk($sformatf("v%0d_ackpulse", n), {30'd0, i_ack, d_ack}, 32'd0);
    endtask

    initial begin
        int grants[4];
        int gtime[4];
        int ng;
        int cyc;
        logic prev;
        logic [3:0] exp_order;  // bit k = 1 -> grant k goes to data

        // dside we addr wdata be waits rdata rd wr be lat rdata err
        vecs[0] = '{1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 32'h2402000A,
                    1'b1, 1'b0, 4'hF, 1, 32'h2402000A, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1, 32'h12345678,
                    1'b1, 1'b0, 4'hF, 2, 32'h12345678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 3, 32'hBAD0BAD0,
                    1'b0, 1'b1, 4'b0011, 4, 32'h12345678, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h1004, 32'h0, 4'h0, 2, 32'hCAFEF00D,
                    1'b1, 1'b0, 4'hF, 3, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h44, 32'h0, 4'b1100, 0, 32'h0000ABCD,
                    1'b1, 1'b0, 4'b1100, 1, 32'h0000ABCD, 1'b0};
        // Stuck waitrequest: the fourth stall abandons the read and zeroes the data.
        vecs[5] = '{1'b0, 1'b0, 32'h2000, 32'h0, 4'h0, 99, 32'hFFFFFFFF,
                    1'b1, 1'b0, 4'hF, 4, 32'h0, 1'b1};

        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        m_waitrequest = 0; m_readdata = 0;
        step();
        step();
        chk("reset_strobes", {30'd0, m_read, m_write}, 32'd0);
        chk("reset_addr", m_address, 32'd0);
        chk("reset_be_wd", {m_byteenable, m_writedata[27:0]}, 32'd0);
        chk("reset_acks_err", {29'd0, i_ack, d_ack, err}, 32'd0);
        chk("reset_rdata", i_rdata | d_rdata, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        repeat (3) step();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Contention with both requests held from reset. Fetch is a read and
        // data is a write, so the active strobe identifies the owner.
        reset = 1'b1;
        i_req = 1; d_req = 1; d_we = 1; i_addr = 32'h1000; d_addr = 32'h2000;
        d_wdata = 32'h55; d_be = 4'hF; m_waitrequest = 0;
        step();
        chk("reset_clears_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;  // I, D, I, D
`else
        exp_order = 4'b1111;  // D, D, D, D
`endif
        ng = 0; prev = 0; cyc = 0;
        while (ng < 4 && cyc < 20) begin
            step();
            if ((m_read || m_write) && !prev) begin
                grants[ng] = m_write ? 1 : 0;
                gtime[ng] = cyc;
                ng++;
            end
            prev = m_read || m_write;
            cyc++;
        end
        chk("cont_ngrants", ng, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) chk($sformatf("cont_owner%0d", k), grants[k], {31'd0, exp_order[k]});
            if (k > 0 && k < ng) chk($sformatf("cont_gap%0d", k), gtime[k] - gtime[k-1], 3);
        end

        // When data goes away, the waiting fetch must still be served.
        d_req = 1'b0;
        cyc = 0;
        while (!i_ack && cyc < 15) begin
            step();
            cyc++;
        end
        chk("fetch_not_dropped", {31'd0, i_ack}, 32'd1);
        i_req = 1'b0;
        step();
        step();

        // Reset in the second stalled cycle of a data write.
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        m_waitrequest = 1;
        step();
        chk("mid_bus1", {31'd0, m_write}, 32'd1);
        step();
        chk("mid_bus2", {31'd0, m_write}, 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_strobe", {31'd0, m_write}, 32'd0);
        chk("mid_rst_ack_err", {30'd0, d_ack, err}, 32'd0);
        reset = 1'b0;
        m_waitrequest = 0;
        step();
        chk("mid_regrant", {31'd0, m_write}, 32'd1);
        step();
        chk("mid_ack", {31'd0, d_ack}, 32'd1);
        d_req = 1'b0;
        step();

        chk("never_both_strobes", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
